push_it: RTL and testbench
==========================

PUSH_IT -- requirements
Module: push_it

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all logic on rising edge.
REQ-002 SHALL have: rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have: trigready  in  1  one-clk pulse, trigger event available.
REQ-004 SHALL have: cycleready  in  1  one-clk pulse, cycle event available.
REQ-005 SHALL have: trignum  in  18  trigger number, valid only in the trigready cycle.
REQ-006 SHALL have: cyclenum  in  18  cycle number, valid only in the cycleready cycle.
REQ-007 SHALL have: timenum  in  36  timestamp, valid in any ready cycle.
REQ-008 SHALL have: busy  in  1  downstream byte sink cannot accept; write SHALL NOT assert while sampled high.
REQ-009 SHALL have: data  out  8  record byte, registered.
REQ-010 SHALL have: write  out  1  one-clk byte strobe, registered.

Function
REQ-011 SHALL, on the edge sampling trigready=1, copy {trignum, timenum} into a trigger holding register and mark it pending; inputs may change on the next cycle.
REQ-012 SHALL, on the edge sampling cycleready=1, copy {cyclenum, timenum} into a separate cycle holding register and mark it pending.
REQ-013 SHALL form a 56-bit record {tag[1:0], num[17:0], time[35:0]}: tag 2'b01 = trigger, 2'b10 = cycle.
REQ-014 SHALL send each record as 7 bytes, MSB first: b0={tag,num[17:12]}, b1=num[11:4], b2={num[3:0],time[35:32]}, b3..b6=time[31:0] big-endian.
REQ-015 SHALL use FSM states IDLE and SEND with a 3-bit byte index 0..6.
REQ-016 IDLE: if either holding register is pending, SHALL load that record into the shift register, clear its pending flag, and enter SEND with index 0; otherwise stay IDLE.
REQ-017 SHALL give the trigger record priority when both are pending; the cycle record SHALL follow after the trigger record completes.
REQ-018 SEND: on each edge with busy=0, SHALL drive data = byte[index], write=1, then increment index; on an edge with busy=1, SHALL drive write=0, hold data and index.
REQ-019 SHALL, after emitting b6, return to IDLE with write=0 on the next edge; at least one idle cycle separates records.
REQ-020 Latency: with busy=0, ready sampled at edge N SHALL give b0 with write=1 after edge N+2 and b6 after edge N+8.
REQ-021 SHALL drop a new event whose holding register is still pending; the existing pending contents SHALL stay unchanged. A holding register frees when IDLE loads it, so one extra event per type may arrive during SEND.
REQ-022 SHALL latch trigready and cycleready asserted in the same cycle into both registers; both records SHALL be sent, trigger first.
REQ-023 SHALL leave data unchanged whenever write=0.

Reset
REQ-024 SHALL, while rst_n=0 and regardless of clk, force data=8'h00, write=0, state=IDLE, index=0, and both pending flags cleared.
REQ-025 SHALL abandon a record in progress when reset is asserted mid-record; the partial record SHALL NOT resume after release.
REQ-026 SHALL resume normal operation on the first clk edge after rst_n rises.

Verification
REQ-027 trignum=0x12345, timenum=0x123456789, trigready pulse, busy=0 -> 7 consecutive write strobes, bytes 52 34 51 23 45 67 89.
REQ-028 trignum=0x3ABCD, timenum=0xFEDCBA987, trigready pulse -> 7A BC DF ED CB A9 87.
REQ-029 cyclenum=0x26789, timenum=0xFEDCBA987, cycleready pulse -> A6 78 9F ED CB A9 87.
REQ-030 busy held high for 5 cycles during b3 of REQ-027 -> write=0 and data stable for those cycles; sequence then resumes at b3, no byte lost or duplicated.
REQ-031 trigready and cycleready in the same cycle -> trigger record first, then at least one idle cycle, then cycle record; two trigready pulses while the first trigger record is in SEND and the second is still pending -> third pulse dropped.
REQ-032 rst_n low during b2 of a record -> write=0 and data=00 immediately; no further bytes after release until a new ready pulse.

Source files
------------

// File: rtl/push_it.sv
// Serialises trigger and cycle events into 7-byte records for a byte sink.
// Each event type has a one-deep holding register; trigger records go first.
module push_it (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        trigready,
  input  logic        cycleready,
  input  logic [17:0] trignum,
  input  logic [17:0] cyclenum,
  input  logic [35:0] timenum,
  input  logic        busy,
  output logic [7:0]  data,
  output logic        write
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t      state_reg, state_next;
  logic [2:0]  idx_reg, idx_next;
  logic        last_reg, last_next;
  logic [55:0] rec_reg, rec_next;
  logic [7:0]  data_reg, data_next;
  logic        write_reg, write_next;
  logic [53:0] trig_hold_reg, trig_hold_next;
  logic [53:0] cyc_hold_reg, cyc_hold_next;
  logic        trig_pend_reg, trig_pend_next;
  logic        cyc_pend_reg, cyc_pend_next;
  logic        load_trig, load_cyc;

  // Byte view of the current record, MSB first; slot 7 is never selected.
  logic [7:0]  rec_byte [0:7];

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_bytes
      if (gi < 7) begin : g_real
        assign rec_byte[gi] = rec_reg[55 - 8*gi -: 8];
      end else begin : g_pad
        assign rec_byte[gi] = 8'h00;
      end
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    last_next  = last_reg;
    rec_next   = rec_reg;
    data_next  = data_reg;
    write_next = 1'b0;
    load_trig  = 1'b0;
    load_cyc   = 1'b0;

    case (state_reg)
      IDLE: begin
        if (trig_pend_reg) begin
          load_trig  = 1'b1;
          rec_next   = {2'b01, trig_hold_reg};
          idx_next   = 3'd0;
          last_next  = 1'b0;
          state_next = SEND;
        end else if (cyc_pend_reg) begin
          load_cyc   = 1'b1;
          rec_next   = {2'b10, cyc_hold_reg};
          idx_next   = 3'd0;
          last_next  = 1'b0;
          state_next = SEND;
        end
      end
      SEND: begin
        // The cycle after b6 is spent returning to IDLE, guaranteeing a gap.
        if (last_reg) begin
          state_next = IDLE;
          idx_next   = 3'd0;
          last_next  = 1'b0;
        end else if (!busy) begin
          data_next  = rec_byte[idx_reg];
          write_next = 1'b1;
          if (idx_reg == 3'd6) begin
            last_next = 1'b1;
          end else begin
            idx_next = idx_reg + 3'd1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // A holding register accepts a new event when empty or being emptied now.
  always_comb begin
    trig_hold_next = trig_hold_reg;
    trig_pend_next = trig_pend_reg & ~load_trig;
    cyc_hold_next  = cyc_hold_reg;
    cyc_pend_next  = cyc_pend_reg & ~load_cyc;
    if (trigready && (!trig_pend_reg || load_trig)) begin
      trig_hold_next = {trignum, timenum};
      trig_pend_next = 1'b1;
    end
    if (cycleready && (!cyc_pend_reg || load_cyc)) begin
      cyc_hold_next = {cyclenum, timenum};
      cyc_pend_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      idx_reg       <= 3'd0;
      last_reg      <= 1'b0;
      rec_reg       <= 56'd0;
      data_reg      <= 8'h00;
      write_reg     <= 1'b0;
      trig_hold_reg <= 54'd0;
      cyc_hold_reg  <= 54'd0;
      trig_pend_reg <= 1'b0;
      cyc_pend_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      idx_reg       <= idx_next;
      last_reg      <= last_next;
      rec_reg       <= rec_next;
      data_reg      <= data_next;
      write_reg     <= write_next;
      trig_hold_reg <= trig_hold_next;
      cyc_hold_reg  <= cyc_hold_next;
      trig_pend_reg <= trig_pend_next;
      cyc_pend_reg  <= cyc_pend_next;
    end
  end

  assign data  = data_reg;
  assign write = write_reg;

endmodule

// File: tb/tb_push_it.sv
// Directed bench for push_it: record byte order, latency, busy stalls,
// priority, dropping of excess events and reset mid-record.
module tb_push_it;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        trigready, cycleready, busy;
  logic [17:0] trignum, cyclenum;
  logic [35:0] timenum;
  logic [7:0]  data;
  logic        write;

  int total = 0;
  int bad   = 0;

  localparam logic [55:0] REC_A = 56'h52_34_51_23_45_67_89;
  localparam logic [55:0] REC_B = 56'h7A_BC_DF_ED_CB_A9_87;
  localparam logic [55:0] REC_C = 56'hA6_78_9F_ED_CB_A9_87;

  push_it dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .trigready (trigready),
    .cycleready(cycleready),
    .trignum   (trignum),
    .cyclenum  (cyclenum),
    .timenum   (timenum),
    .busy      (busy),
    .data      (data),
    .write     (write)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called right after the edge that sampled the ready pulse (edge N).
  task automatic run_record(input string tag, input logic [55:0] rec,
                            input int busy_at, input int busy_len);
    logic [7:0] prev;
    prev = 8'h00;
    tick;
    chk({tag, " gap write"}, {7'd0, write}, 8'd0);
    for (int k = 0; k < 7; k++) begin
      if (k == busy_at) begin
        busy = 1'b1;
        for (int j = 0; j < busy_len; j++) begin
          tick;
          chk($sformatf("%s stall%0d write", tag, j), {7'd0, write}, 8'd0);
          chk($sformatf("%s stall%0d data", tag, j), data, prev);
        end
        busy = 1'b0;
      end
      tick;
      chk($sformatf("%s b%0d write", tag, k), {7'd0, write}, 8'd1);
      chk($sformatf("%s b%0d data", tag, k), data, rec[55 - 8*k -: 8]);
      prev = rec[55 - 8*k -: 8];
    end
    tick;
    chk({tag, " end write"}, {7'd0, write}, 8'd0);
    chk({tag, " end data"}, data, prev);
    $display("record %s expected %h checked", tag, rec);
  endtask

  task automatic pulse(input logic t, input logic c, input logic [17:0] tn,
                       input logic [17:0] cn, input logic [35:0] tm);
    trigready  = t;
    cycleready = c;
    trignum    = tn;
    cyclenum   = cn;
    timenum    = tm;
    tick;
    trigready  = 1'b0;
    cycleready = 1'b0;
    trignum    = 18'h3FFFF;
    cyclenum   = 18'h3FFFF;
    timenum    = 36'hFFFFFFFFF;
  endtask

  initial begin
    trigready = 0; cycleready = 0; busy = 0;
    trignum = 0; cyclenum = 0; timenum = 0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("reset async write", {7'd0, write}, 8'd0);
    chk("reset async data", data, 8'h00);
    repeat (3) tick;
    chk("reset held write", {7'd0, write}, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) tick;
    chk("idle write", {7'd0, write}, 8'd0);
    $display("reset sequence checked");

    // Basic trigger records
    pulse(1, 0, 18'h12345, 18'h0, 36'h123456789);
    run_record("trigA", REC_A, -1, 0);
    pulse(1, 0, 18'h3ABCD, 18'h0, 36'hFEDCBA987);
    run_record("trigB", REC_B, -1, 0);
    pulse(0, 1, 18'h0, 18'h26789, 36'hFEDCBA987);
    run_record("cycC", REC_C, -1, 0);

    // Busy stall for 5 cycles at b3
    pulse(1, 0, 18'h12345, 18'h0, 36'h123456789);
    run_record("busyA", REC_A, 3, 5);

    // Simultaneous events: trigger first, then cycle after a gap
    pulse(1, 1, 18'h3ABCD, 18'h26789, 36'hFEDCBA987);
    run_record("simT", REC_B, -1, 0);
    run_record("simC", REC_C, -1, 0);

    // Second trigger held pending during SEND; third one dropped
    pulse(1, 0, 18'h12345, 18'h0, 36'h123456789);
    tick;
    chk("drop gap write", {7'd0, write}, 8'd0);
    for (int k = 0; k < 7; k++) begin
      if (k == 1) begin
        trigready = 1'b1; trignum = 18'h3ABCD; timenum = 36'hFEDCBA987;
      end else if (k == 3) begin
        trigready = 1'b1; trignum = 18'h00001; timenum = 36'h000000000;
      end else begin
        trigready = 1'b0; trignum = 18'h3FFFF; timenum = 36'hFFFFFFFFF;
      end
      tick;
      chk($sformatf("drop first b%0d write", k), {7'd0, write}, 8'd1);
      chk($sformatf("drop first b%0d data", k), data, REC_A[55 - 8*k -: 8]);
    end
    trigready = 1'b0;
    tick;
    chk("drop first end write", {7'd0, write}, 8'd0);
    run_record("dropB", REC_B, -1, 0);
    for (int i = 0; i < 12; i++) begin
      tick;
      chk($sformatf("dropped third idle%0d", i), {7'd0, write}, 8'd0);
    end
    $display("record drop sequence checked");

    // Reset during b2
    pulse(1, 0, 18'h12345, 18'h0, 36'h123456789);
    tick;
    for (int k = 0; k < 3; k++) begin
      tick;
      chk($sformatf("rstmid b%0d data", k), data, REC_A[55 - 8*k -: 8]);
    end
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid async write", {7'd0, write}, 8'd0);
    chk("rstmid async data", data, 8'h00);
    tick;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick;
      chk($sformatf("rstmid idle%0d write", i), {7'd0, write}, 8'd0);
    end
    pulse(0, 1, 18'h0, 18'h26789, 36'hFEDCBA987);
    run_record("afterRst", REC_C, -1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
